rank_writeback: RTL and testbench
=================================

Name: rank_writeback

Overview:
- Downstream stage of the PageRank read/compute engine. It consumes the stream of updated 64-bit per-vertex ranks in vertex-id order.
- It packs 8 ranks into each 512-bit line and writes the lines to the rank output array through the AXI write channels (aw/w/b).
- It reports completion and any write error for the round so the controller can start the next iteration or answer the ROUND_DONE soft-register read.

Parameters:
- INT_W, 64, width of one rank value in bits.
- LANES, 8, ranks per 512-bit line (LANES*INT_W = 512).
- AXI_ID, 2, value driven on awid_m/wid_m.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a round; sampled only in IDLE.
- base_addr  in  64  byte address of the rank output array; bits [5:0] are ignored and treated as 0.
- n_vertices  in  64  number of ranks in the round; latched on start.
- rank_valid  in  1  upstream rank available.
- rank_data  in  64  rank value.
- rank_ready  out  1  rank accepted when rank_valid && rank_ready.
- awid_m / awaddr_m / awlen_m / awsize_m / awvalid_m  out  16/64/8/3/1  AXI write address channel.
- awready_m  in  1.
- wid_m / wdata_m / wstrb_m / wlast_m / wvalid_m  out  16/512/64/1/1  AXI write data channel.
- wready_m  in  1.
- bid_m / bresp_m / bvalid_m  in  16/2/1  AXI write response channel.
- bready_m  out  1.
- done  out  1  level; high from round completion until the next accepted start.
- err  out  1  sticky; set when any bresp_m != 0 during the round; cleared on start.
- lines_written  out  64  count of B responses received this round.

Behaviour:
- Reset (asynchronous): state = IDLE. All outputs are 0: rank_ready, awvalid_m, wvalid_m, bready_m, done, err, lines_written, wdata_m, wstrb_m. The lane buffer and all counters clear. A reset mid-round abandons any in-flight transaction; no B response is awaited.
- Constant outputs: awid_m = wid_m = AXI_ID, awlen_m = 0 (single beat), awsize_m = 3'b110, wlast_m = 1 whenever wvalid_m is high.
- State machine: IDLE, FILL, SEND, RESP.
- IDLE, on start:
  - Latch n_vertices and the aligned base_addr; clear remaining, lane_idx, line_idx, err, lines_written, done.
  - If n_vertices == 0: go to IDLE with done = 1 on the next cycle.
  - Otherwise go to FILL.
  - start in any other state is ignored.
- FILL:
  - rank_ready = 1.
  - On handshake: rank_data is written to lane lane_idx, bits [64*lane_idx+63 : 64*lane_idx]. lane_idx increments and remaining decrements.
  - Go to SEND when lane_idx reaches LANES-1 on a handshake, or when remaining reaches 1 on a handshake (final, partial line).
  - Lane 0 always holds the lowest vertex id of the line.
- SEND:
  - Registered outputs; awvalid_m and wvalid_m are asserted the cycle after the transition.
  - awaddr_m = base + line_idx*64.
  - wdata_m = lane buffer, with unfilled lanes driven to 0.
  - wstrb_m has 8 bits set per filled lane, lane 0 in bits [7:0]; a full line is 64'hFFFF_FFFF_FFFF_FFFF.
  - rank_ready = 0.
  - awvalid_m and wvalid_m drop independently on their own handshakes, with either order or the same cycle allowed.
  - Go to RESP when both have completed.
- RESP:
  - bready_m = 1.
  - On bvalid_m: lines_written increments, and err sets if bresp_m != 0.
  - Then, if remaining == 0: done = 1, go to IDLE. Otherwise clear lane_idx and the lane buffer, increment line_idx, go to FILL.
  - bid_m is not checked.
- Ordering and backpressure:
  - Only one line is in flight at a time.
  - rank_ready stays low outside FILL, and after the last rank of the round, so extra upstream ranks are never consumed.
- Latency:
  - 8th rank accepted at cycle t → awvalid_m/wvalid_m high at t+1.
  - B handshake at cycle u → rank_ready high at u+1.
- Arithmetic: line_idx*64 is a 64-bit add; addresses wrap modulo 2^64 with no error reported.

Test Plan:
- Full lines: base = 0x1000, n = 16, ranks 1..16 with always-ready slave → two writes at 0x1000 and 0x1040. Line 0 has lane0 = 1 … lane7 = 8, line 1 has lane0 = 9 … lane7 = 16. wstrb is all ones on both; done = 1, lines_written = 2, err = 0.
- Partial final line: n = 11, base = 0x2003 → writes at 0x2000 and 0x2040. The second write has wstrb = 64'h0000_0000_00FF_FFFF and lanes 3–7 = 0.
- Independent handshakes: awready_m held low 5 cycles with wready_m = 1, then the reverse → each valid stays high until its own handshake. Exactly one write per line; rank_ready stays 0 until the B handshake.
- Upstream stalls and extra data: rank_valid toggling every other cycle with rank_valid held high after the 8th rank of n = 8 → exactly 8 ranks consumed, one write issued, rank_ready = 0 afterwards.
- Error and zero size: bresp_m = 2'b10 on the first of two lines → err = 1 and stays set through done. A new start with n = 0 clears err and raises done on the next cycle with no AXI activity.
- Async reset mid-SEND: rst asserted while awvalid_m = 1 → all outputs 0 immediately, no clock edge required. After release, start with n = 8 completes normally from line 0.

Source files
------------

// File: rtl/rank_writeback.sv
// Packs the in-order rank stream into 512-bit lines and writes each line as one AXI single-beat write.
// Latency: the last rank of a line raises awvalid_m/wvalid_m next cycle; a B handshake reopens rank_ready next cycle.
// Backpressure: rank_ready is high only in FILL; only one line is in flight, so AXI stalls hold the upstream off.
module rank_writeback #(
  parameter int          INT_W  = 64,
  parameter int          LANES  = 8,
  parameter logic [15:0] AXI_ID = 16'd2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              base_addr,
  input  logic [63:0]              n_vertices,
  input  logic                     rank_valid,
  input  logic [INT_W-1:0]         rank_data,
  output logic                     rank_ready,
  output logic [15:0]              awid_m,
  output logic [63:0]              awaddr_m,
  output logic [7:0]               awlen_m,
  output logic [2:0]               awsize_m,
  output logic                     awvalid_m,
  input  logic                     awready_m,
  output logic [15:0]              wid_m,
  output logic [INT_W*LANES-1:0]   wdata_m,
  output logic [INT_W*LANES/8-1:0] wstrb_m,
  output logic                     wlast_m,
  output logic                     wvalid_m,
  input  logic                     wready_m,
  input  logic [15:0]              bid_m,
  input  logic [1:0]               bresp_m,
  input  logic                     bvalid_m,
  output logic                     bready_m,
  output logic                     done,
  output logic                     err,
  output logic [63:0]              lines_written
);

  localparam int          LINE_W    = INT_W * LANES;
  localparam int          STRB_W    = LINE_W / 8;
  localparam int          LANE_B    = INT_W / 8;
  localparam int          LIDX_W    = $clog2(LANES);
  localparam int          LINE_SH   = $clog2(STRB_W);
  localparam logic [63:0] ADDR_MASK = ~(64'(STRB_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, FILL, SEND, RESP} state_t;

  state_t              state;
  logic [63:0]         base_q;
  logic [63:0]         remaining;
  logic [LIDX_W-1:0]   lane_idx;
  logic [63:0]         line_idx;
  logic [LINE_W-1:0]   lane_buf;
  logic [STRB_W-1:0]   strb_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                done_q;
  logic                err_q;
  logic [63:0]         lines_q;

  logic                last_lane;
  logic                aw_done;
  logic                w_done;
  logic                unused_bid;

  // Response IDs are not checked: only one write is ever outstanding.
  assign unused_bid = ^bid_m;

  assign last_lane = (lane_idx == LIDX_W'(LANES - 1));
  assign aw_done   = !awvalid_q || awready_m;
  assign w_done    = !wvalid_q || wready_m;

  assign awid_m        = AXI_ID;
  assign wid_m         = AXI_ID;
  assign awlen_m       = 8'd0;
  assign awsize_m      = 3'(LINE_SH);
  // Line address is a plain 64-bit add, so it wraps silently at the top of the address space.
  assign awaddr_m      = base_q + (line_idx << LINE_SH);
  assign awvalid_m     = awvalid_q;
  assign wvalid_m      = wvalid_q;
  assign wlast_m       = wvalid_q;
  assign wdata_m       = lane_buf;
  assign wstrb_m       = strb_q;
  assign rank_ready    = (state == FILL);
  assign bready_m      = (state == RESP);
  assign done          = done_q;
  assign err           = err_q;
  assign lines_written = lines_q;

  // Round sequencing: fill a line, issue aw/w independently, wait for B, repeat until all ranks are written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      remaining <= '0;
      lane_idx  <= '0;
      line_idx  <= '0;
      lane_buf  <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lines_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr & ADDR_MASK;
            remaining <= n_vertices;
            lane_idx  <= '0;
            line_idx  <= '0;
            lane_buf  <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            lines_q   <= '0;
            // An empty round completes immediately without touching the bus.
            if (n_vertices == 64'd0) begin
              done_q <= 1'b1;
            end else begin
              done_q <= 1'b0;
              state  <= FILL;
            end
          end
        end
        FILL: begin
          if (rank_valid) begin
            lane_buf[lane_idx*INT_W +: INT_W] <= rank_data;
            strb_q[lane_idx*LANE_B +: LANE_B] <= '1;
            lane_idx  <= lane_idx + 1'b1;
            remaining <= remaining - 64'd1;
            // A full line, or the final rank of a partial line, goes out next cycle.
            if (last_lane || remaining == 64'd1) begin
              state     <= SEND;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (awvalid_q && awready_m) awvalid_q <= 1'b0;
          if (wvalid_q && wready_m)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)      state     <= RESP;
        end
        RESP: begin
          if (bvalid_m) begin
            lines_q <= lines_q + 64'd1;
            if (bresp_m != 2'b00) err_q <= 1'b1;
            if (remaining == 64'd0) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              lane_idx <= '0;
              lane_buf <= '0;
              strb_q   <= '0;
              line_idx <= line_idx + 64'd1;
              state    <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_writeback.sv
// Bench for rank_writeback: table of rounds plus a hand-written mid-SEND reset sequence.
// Expected AXI writes come from a line model pushed at round start and popped on each handshake.
// A negedge bus model plays upstream source and AXI slave with programmable stalls.
module tb_rank_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  base_addr;
  logic [63:0]  n_vertices;
  logic         rank_valid;
  logic [63:0]  rank_data;
  logic         rank_ready;
  logic [15:0]  awid_m;
  logic [63:0]  awaddr_m;
  logic [7:0]   awlen_m;
  logic [2:0]   awsize_m;
  logic         awvalid_m;
  logic         awready_m;
  logic [15:0]  wid_m;
  logic [511:0] wdata_m;
  logic [63:0]  wstrb_m;
  logic         wlast_m;
  logic         wvalid_m;
  logic         wready_m;
  logic [15:0]  bid_m;
  logic [1:0]   bresp_m;
  logic         bvalid_m;
  logic         bready_m;
  logic         done;
  logic         err;
  logic [63:0]  lines_written;

  rank_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_vertices(n_vertices),
    .rank_valid(rank_valid), .rank_data(rank_data), .rank_ready(rank_ready),
    .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
    .awvalid_m(awvalid_m), .awready_m(awready_m),
    .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
    .wvalid_m(wvalid_m), .wready_m(wready_m),
    .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
    .done(done), .err(err), .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] base;
    int          n;
    logic [63:0] rank0;
    int          aw_stall;
    int          w_stall;
    bit          toggle;
    bit          extra;
    int          err_line;
    int          exp_lines;
    bit          exp_err;
  } case_t;

  // Scoreboard queues
  logic [63:0]  q_aw[$];
  logic [511:0] q_wd[$];
  logic [63:0]  q_ws[$];

  // Bus model configuration and bookkeeping
  int          aw_stall = 0, w_stall = 0, err_line = -1;
  bit          toggle = 0, extra = 0, phase = 0;
  int          up_left = 0, accepted = 0, extra_acc = 0, n_cur = 0;
  logic [63:0] up_val = '0;
  int          aw_cnt = 0, w_cnt = 0, aw_out = 0, w_out = 0, aw_tot = 0, w_tot = 0, b_line = 0;
  bit          b_fire = 0, prev_aw = 0, prev_rr = 0, lf_flag = 0, bf_flag = 0;
  int          lf_cyc = 0, bf_cyc = 0, viol = 0, lat_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [63:0] base, input int n, input logic [63:0] rank0);
    logic [63:0]  ab;
    logic [511:0] d;
    logic [63:0]  s;
    int           nl, cnt;
    ab = {base[63:6], 6'b0};
    nl = (n + 7) / 8;
    for (int i = 0; i < nl; i++) begin
      d   = '0;
      s   = '0;
      cnt = (n - 8 * i > 8) ? 8 : n - 8 * i;
      for (int k = 0; k < cnt; k++) begin
        d[k*64 +: 64] = rank0 + 64'(8 * i + k);
        s[k*8 +: 8]   = 8'hFF;
      end
      q_aw.push_back(ab + 64'(i) * 64'd64);
      q_wd.push_back(d);
      q_ws.push_back(s);
    end
  endtask

  // Bus model: each negedge decides what will handshake on the following posedge.
  initial begin
    rank_valid = 0; rank_data = '0; awready_m = 0; wready_m = 0;
    bvalid_m = 0; bresp_m = 2'b00; bid_m = 16'd2;
    forever begin
      @(negedge clk);
      if (rst) begin
        rank_valid = 0; awready_m = 0; wready_m = 0; bvalid_m = 0; bresp_m = 2'b00;
        aw_cnt = 0; w_cnt = 0; aw_out = 0; w_out = 0; b_fire = 0;
        prev_aw = 0; prev_rr = 0; lf_flag = 0; bf_flag = 0;
      end else begin
        // Latency: last rank of a line -> valids next cycle; B handshake -> rank_ready next cycle.
        if (awvalid_m && !prev_aw) begin
          if (!lf_flag || cyc != lf_cyc + 1) lat_viol++;
          lf_flag = 0;
        end
        if (rank_ready && !prev_rr && bf_flag) begin
          if (cyc != bf_cyc + 1) lat_viol++;
          bf_flag = 0;
        end
        if (rank_ready && (awvalid_m || wvalid_m || (bvalid_m && !b_fire) || aw_out > 0 || w_out > 0))
          viol++;
        // B channel
        if (b_fire) begin
          bvalid_m = 0;
          b_fire = 0;
        end
        if (!bvalid_m && aw_out > 0 && w_out > 0) begin
          bvalid_m = 1;
          bresp_m  = (b_line == err_line) ? 2'b10 : 2'b00;
          b_line++;
          aw_out--;
          w_out--;
        end
        b_fire = bvalid_m && bready_m;
        if (b_fire) begin
          bf_cyc = cyc;
          bf_flag = 1;
        end
        // Upstream source
        if (up_left > 0) begin
          rank_valid = toggle ? phase : 1'b1;
          rank_data  = up_val;
        end else begin
          rank_valid = extra;
          rank_data  = 64'hDEAD_BEEF_0BAD_F00D;
        end
        phase = ~phase;
        if (rank_valid && rank_ready) begin
          if (up_left > 0) begin
            accepted++;
            up_left--;
            up_val = up_val + 64'd1;
            if (accepted % 8 == 0 || up_left == 0) begin
              lf_cyc = cyc;
              lf_flag = 1;
            end
          end else begin
            extra_acc++;
          end
        end
        // AW channel
        awready_m = awvalid_m && (aw_cnt >= aw_stall);
        if (awvalid_m) aw_cnt++; else aw_cnt = 0;
        if (awvalid_m && awready_m) begin
          aw_tot++;
          aw_out++;
          if (q_aw.size() == 0) begin
            check("aw_unexpected", awaddr_m, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("awaddr", awaddr_m, q_aw.pop_front());
            check("aw_const", {40'd0, awid_m, awlen_m}, {40'd0, 16'd2, 8'd0});
            check("awsize", 64'(awsize_m), 64'd6);
          end
        end
        // W channel
        wready_m = wvalid_m && (w_cnt >= w_stall);
        if (wvalid_m) w_cnt++; else w_cnt = 0;
        if (wvalid_m && wready_m) begin
          w_tot++;
          w_out++;
          if (q_wd.size() == 0) begin
            check("w_unexpected", wstrb_m, 64'h0);
          end else begin
            check512("wdata", wdata_m, q_wd.pop_front());
            check("wstrb", wstrb_m, q_ws.pop_front());
            check("w_const", {47'd0, wlast_m, wid_m}, {47'd0, 1'b1, 16'd2});
          end
        end
        prev_aw = awvalid_m;
        prev_rr = rank_ready;
      end
    end
  end

  task automatic run_case(input case_t c, input string nm);
    aw_stall = c.aw_stall; w_stall = c.w_stall; toggle = c.toggle; extra = c.extra;
    err_line = c.err_line; n_cur = c.n;
    accepted = 0; extra_acc = 0; aw_tot = 0; w_tot = 0; b_line = 0;
    viol = 0; lat_viol = 0;
    push_expected(c.base, c.n, c.rank0);
    up_val = c.rank0;
    up_left = c.n;
    @(negedge clk);
    bf_flag = 0;
    start = 1; base_addr = c.base; n_vertices = 64'(c.n);
    @(negedge clk);
    start = 0;
    check({nm, "_done_after_start"}, 64'(done), 64'(c.n == 0));
    check({nm, "_err_after_start"}, 64'(err), 64'd0);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    check({nm, "_done_reached"}, 64'(done), 64'd1);
    repeat (6) @(negedge clk);
    check({nm, "_lines_written"}, lines_written, 64'(c.exp_lines));
    check({nm, "_err"}, 64'(err), 64'(c.exp_err));
    check({nm, "_done_held"}, 64'(done), 64'd1);
    check({nm, "_aw_count"}, 64'(aw_tot), 64'(c.exp_lines));
    check({nm, "_w_count"}, 64'(w_tot), 64'(c.exp_lines));
    check({nm, "_ranks_taken"}, 64'(accepted), 64'(c.n));
    check({nm, "_extra_taken"}, 64'(extra_acc), 64'd0);
    check({nm, "_rank_ready_idle"}, 64'(rank_ready), 64'd0);
    check({nm, "_ready_while_busy"}, 64'(viol), 64'd0);
    check({nm, "_latency"}, 64'(lat_viol), 64'd0);
    check({nm, "_queue_left"}, 64'(q_aw.size() + q_wd.size()), 64'd0);
    extra = 0;
    toggle = 0;
    up_left = 0;
    q_aw.delete(); q_wd.delete(); q_ws.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  case_t tbl[8];
  case_t post;

  initial begin
    tbl[0] = '{64'h1000, 16, 64'd1, 0, 0, 1'b0, 1'b0, -1, 2, 1'b0};
    tbl[1] = '{64'h2003, 11, 64'h200, 0, 0, 1'b0, 1'b0, -1, 2, 1'b0};
    tbl[2] = '{64'h3000, 16, 64'h300, 5, 0, 1'b0, 1'b0, -1, 2, 1'b0};
    tbl[3] = '{64'h4000, 8, 64'h400, 0, 5, 1'b0, 1'b0, -1, 1, 1'b0};
    tbl[4] = '{64'h5000, 8, 64'h500, 0, 0, 1'b1, 1'b1, -1, 1, 1'b0};
    tbl[5] = '{64'h6000, 16, 64'h600, 1, 2, 1'b0, 1'b0, 0, 2, 1'b1};
    tbl[6] = '{64'h6800, 0, 64'h0, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFC5, 13, 64'h900, 0, 0, 1'b0, 1'b0, -1, 2, 1'b0};
    post   = '{64'h8000, 8, 64'h800, 0, 0, 1'b0, 1'b0, -1, 1, 1'b0};

    rst = 1; start = 0; base_addr = '0; n_vertices = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {58'd0, rank_ready, awvalid_m, wvalid_m, bready_m, done, err}, 64'd0);
    check("reset_lines", lines_written, 64'd0);
    check("reset_wstrb", wstrb_m, 64'd0);
    check512("reset_wdata", wdata_m, 512'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("case%0d", i));

    // Asynchronous reset while a line is stuck in SEND.
    aw_stall = 1000; w_stall = 0; toggle = 0; extra = 0; err_line = -1;
    push_expected(64'h7000, 8, 64'h700);
    up_val = 64'h700; up_left = 8; accepted = 0;
    @(negedge clk);
    start = 1; base_addr = 64'h7000; n_vertices = 64'd8;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && !awvalid_m; i++) @(negedge clk);
    check("rst_pre_awvalid", 64'(awvalid_m), 64'd1);
    rst = 1;
    #1;
    check("rst_async_ctl", {58'd0, rank_ready, awvalid_m, wvalid_m, bready_m, done, err}, 64'd0);
    check("rst_async_lines", lines_written, 64'd0);
    check("rst_async_wstrb", wstrb_m, 64'd0);
    check512("rst_async_wdata", wdata_m, 512'd0);
    up_left = 0;
    repeat (2) @(negedge clk);
    q_aw.delete(); q_wd.delete(); q_ws.delete();
    rst = 0;
    repeat (2) @(negedge clk);
    run_case(post, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
